// File: rtl/qpu_exu_trigger_pkg.sv
// Shared widths and FSM encoding for the QPU execution-unit trigger engine.
// Width defaults track the QPU-wide timeline and event bus definitions.
package qpu_exu_trigger_pkg;

    localparam int unsigned QPU_TIME_WIDTH            = 16;
    localparam int unsigned QPU_EVENT_NUM             = 8;
    localparam int unsigned QPU_EVNET_WIRE_FULL_WIDTH = 64;
    localparam int unsigned QPU_TRIG_HOLD_CYC         = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2,
        StErr   = 2'd3
    } trig_state_e;

    // Hold counter only needs to reach hold_cyc-1; keep at least one bit.
    function automatic int unsigned hold_cnt_width(input int unsigned hold_cyc);
        return (hold_cyc > 1) ? $clog2(hold_cyc) : 1;
    endfunction

endpackage

// File: rtl/qpu_trig_hold.sv
// Released-event output register with a down-counter that keeps each capture
// valid for exactly HOLD_CYC cycles; a new capture overwrites and reloads.
module qpu_trig_hold
    import qpu_exu_trigger_pkg::*;
#(
    parameter int unsigned EVENT_NUM = QPU_EVENT_NUM,
    parameter int unsigned EVENT_W   = QPU_EVNET_WIRE_FULL_WIDTH,
    parameter int unsigned HOLD_CYC  = QPU_TRIG_HOLD_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 cap_i,
    input  logic [EVENT_NUM-1:0] cap_valid_i,
    input  logic [EVENT_W-1:0]   cap_data_i,
    output logic [EVENT_NUM-1:0] evt_valid_o,
    output logic [EVENT_W-1:0]   evt_data_o
);

    localparam int unsigned CntW = hold_cnt_width(HOLD_CYC);
    localparam logic [CntW-1:0] Reload = CntW'(HOLD_CYC - 1);

    logic [CntW-1:0]      cnt_q;
    logic [EVENT_NUM-1:0] valid_q;
    logic [EVENT_W-1:0]   data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            // Timeline stopped: drop the release but keep the last data word.
            cnt_q   <= '0;
            valid_q <= '0;
        end else if (cap_i) begin
            cnt_q   <= Reload;
            valid_q <= cap_valid_i;
            data_q  <= cap_data_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end else begin
            valid_q <= '0;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_data_o  = data_q;

endmodule

// File: rtl/qpu_exu_trigger.sv
// Timeline counter and fire/stall/miss control on the read side of the
// execution-unit time and event queues.
module qpu_exu_trigger
    import qpu_exu_trigger_pkg::*;
#(
    parameter int unsigned TIME_W    = QPU_TIME_WIDTH,
    parameter int unsigned EVENT_NUM = QPU_EVENT_NUM,
    parameter int unsigned EVENT_W   = QPU_EVNET_WIRE_FULL_WIDTH,
    parameter int unsigned HOLD_CYC  = QPU_TRIG_HOLD_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    input  logic                 tiq_head_valid,
    input  logic [TIME_W-1:0]    tiq_head_time,
    input  logic                 tiq_clk_ena,
    output logic                 trigger_o,
    output logic [TIME_W-1:0]    timer_o,
    input  logic [EVENT_NUM-1:0] evq_i_valid,
    input  logic [EVENT_W-1:0]   evq_i_data,
    output logic [EVENT_NUM-1:0] evt_o_valid,
    output logic [EVENT_W-1:0]   evt_o_data,
    output logic                 stall_o,
    output logic                 miss_err_o
);

    trig_state_e       state_q;
    logic [TIME_W-1:0] timer_q;
    logic              stall_q;
    logic              miss_q;

    logic              hit;
    logic              miss;
    logic              fire;
    logic [TIME_W-1:0] diff;

    assign hit  = tiq_head_valid && (timer_q == tiq_head_time);
    // Head is in the past when timer-head is positive in two's complement,
    // which stays correct across timeline wrap.
    assign diff = timer_q - tiq_head_time;
    assign miss = tiq_head_valid && !diff[TIME_W-1] && (diff != '0);

    // Gated by run_en so a shutdown cycle never pops entries nobody captures.
    assign trigger_o = run_en && (((state_q == StRun) && hit) || (state_q == StStall));
    assign fire      = trigger_o && tiq_clk_ena;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            stall_q <= 1'b0;
            miss_q  <= 1'b0;
        end else if (!run_en) begin
            state_q <= StIdle;
            timer_q <= '0;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StRun;
                    timer_q <= '0;
                end
                StRun: begin
                    if (hit) begin
                        if (tiq_clk_ena) begin
                            timer_q <= timer_q + TIME_W'(1);
                        end else begin
                            state_q <= StStall;
                            stall_q <= 1'b1;
                        end
                    end else if (miss) begin
                        state_q <= StErr;
                        miss_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TIME_W'(1);
                    end
                end
                StStall: begin
                    if (tiq_clk_ena) begin
                        state_q <= StRun;
                        stall_q <= 1'b0;
                        timer_q <= timer_q + TIME_W'(1);
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: begin
                    state_q <= StIdle;
                    timer_q <= '0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign timer_o    = timer_q;
    assign stall_o    = stall_q;
    assign miss_err_o = miss_q;

    qpu_trig_hold #(
        .EVENT_NUM (EVENT_NUM),
        .EVENT_W   (EVENT_W),
        .HOLD_CYC  (HOLD_CYC)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (!run_en),
        .cap_i       (fire),
        .cap_valid_i (evq_i_valid),
        .cap_data_i  (evq_i_data),
        .evt_valid_o (evt_o_valid),
        .evt_data_o  (evt_o_data)
    );

endmodule

// File: tb/tb_qpu_exu_trigger.sv
// Directed bench for qpu_exu_trigger: released events are checked against a
// scoreboard queue, timing/stall/miss behaviour by step-wise assertions.
module tb_qpu_exu_trigger;

    localparam int unsigned TIME_W    = 16;
    localparam int unsigned EVENT_NUM = 8;
    localparam int unsigned EVENT_W   = 64;
    localparam int unsigned HOLD_CYC  = 4;

    typedef struct packed {
        logic [EVENT_NUM-1:0] v;
        logic [EVENT_W-1:0]   d;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 run_en;
    logic                 tiq_head_valid;
    logic [TIME_W-1:0]    tiq_head_time;
    logic                 tiq_clk_ena;
    logic                 trigger_o;
    logic [TIME_W-1:0]    timer_o;
    logic [EVENT_NUM-1:0] evq_i_valid;
    logic [EVENT_W-1:0]   evq_i_data;
    logic [EVENT_NUM-1:0] evt_o_valid;
    logic [EVENT_W-1:0]   evt_o_data;
    logic                 stall_o;
    logic                 miss_err_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    qpu_exu_trigger #(
        .TIME_W    (TIME_W),
        .EVENT_NUM (EVENT_NUM),
        .EVENT_W   (EVENT_W),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run_en         (run_en),
        .tiq_head_valid (tiq_head_valid),
        .tiq_head_time  (tiq_head_time),
        .tiq_clk_ena    (tiq_clk_ena),
        .trigger_o      (trigger_o),
        .timer_o        (timer_o),
        .evq_i_valid    (evq_i_valid),
        .evq_i_data     (evq_i_data),
        .evt_o_valid    (evt_o_valid),
        .evt_o_data     (evt_o_data),
        .stall_o        (stall_o),
        .miss_err_o     (miss_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [EVENT_NUM-1:0] v, input logic [EVENT_W-1:0] d);
        exp_t e;
        e.v = v;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: each fresh release on the output pops one entry.
    initial begin
        logic [EVENT_NUM-1:0] prev_v;
        logic [EVENT_W-1:0]   prev_d;
        exp_t                 e;
        prev_v = '0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            if (!rst && evt_o_valid != '0 && (evt_o_valid != prev_v || evt_o_data != prev_d)) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_valid", 64'(evt_o_valid), 64'(e.v));
                    chk("sb_data", evt_o_data, e.d);
                end
            end
            prev_v = evt_o_valid;
            prev_d = evt_o_data;
        end
    end

    initial begin
        rst            = 1'b1;
        run_en         = 1'b0;
        tiq_head_valid = 1'b0;
        tiq_head_time  = '0;
        tiq_clk_ena    = 1'b1;
        evq_i_valid    = '0;
        evq_i_data     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_timer", 64'(timer_o), 64'd0);
        chk("rst_trigger", 64'(trigger_o), 64'd0);
        chk("rst_evt_valid", 64'(evt_o_valid), 64'd0);
        chk("rst_evt_data", evt_o_data, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_miss", 64'(miss_err_o), 64'd0);

        // Basic fire at head 5 with immediate grant
        tiq_head_time  = 16'h0005;
        tiq_head_valid = 1'b1;
        evq_i_valid    = 8'hA5;
        evq_i_data     = 64'h1111_2222_3333_4444;
        run_en         = 1'b1;
        tick();
        chk("t1_timer0", 64'(timer_o), 64'd0);
        chk("t1_trig0", 64'(trigger_o), 64'd0);
        repeat (5) tick();
        chk("t1_timer5", 64'(timer_o), 64'd5);
        chk("t1_trig5", 64'(trigger_o), 64'd1);
        push_exp(8'hA5, 64'h1111_2222_3333_4444);
        tick();
        chk("t1_timer6", 64'(timer_o), 64'd6);
        chk("t1_trig6", 64'(trigger_o), 64'd0);
        tiq_head_valid = 1'b0;
        evq_i_valid    = 8'hFF;
        evq_i_data     = 64'hDEAD_BEEF_0000_0000;
        for (int i = 0; i < int'(HOLD_CYC); i++) begin
            chk("t1_hold_valid", 64'(evt_o_valid), 64'hA5);
            chk("t1_hold_data", evt_o_data, 64'h1111_2222_3333_4444);
            tick();
        end
        chk("t1_hold_end", 64'(evt_o_valid), 64'd0);
        chk("t1_data_kept", evt_o_data, 64'h1111_2222_3333_4444);
        chk("t1_timer10", 64'(timer_o), 64'd10);
        run_en = 1'b0;
        tick();
        chk("t1_idle_timer", 64'(timer_o), 64'd0);

        // Stall at head 3 until grant
        tiq_head_time  = 16'h0003;
        tiq_head_valid = 1'b1;
        tiq_clk_ena    = 1'b0;
        evq_i_valid    = 8'h3C;
        evq_i_data     = 64'h0BAD_F00D_CAFE_0003;
        run_en         = 1'b1;
        tick();
        repeat (3) tick();
        chk("t2_hit_trig", 64'(trigger_o), 64'd1);
        chk("t2_hit_stall", 64'(stall_o), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall", 64'(stall_o), 64'd1);
            chk("t2_frozen", 64'(timer_o), 64'd3);
            chk("t2_trig_held", 64'(trigger_o), 64'd1);
            chk("t2_no_evt", 64'(evt_o_valid), 64'd0);
            if (i == 2) begin
                push_exp(8'h3C, 64'h0BAD_F00D_CAFE_0003);
                tiq_clk_ena = 1'b1;
            end
            tick();
        end
        chk("t2_grant_timer", 64'(timer_o), 64'd4);
        chk("t2_grant_stall", 64'(stall_o), 64'd0);
        chk("t2_grant_evt", 64'(evt_o_valid), 64'h3C);
        tiq_head_valid = 1'b0;
        run_en = 1'b0;
        tick();
        chk("t2_idle_evt", 64'(evt_o_valid), 64'd0);

        // Miss: head 2 presented at timer 8
        run_en = 1'b1;
        tick();
        repeat (8) tick();
        chk("t3_timer8", 64'(timer_o), 64'd8);
        tiq_head_time  = 16'h0002;
        tiq_head_valid = 1'b1;
        tick();
        chk("t3_miss", 64'(miss_err_o), 64'd1);
        chk("t3_err_timer", 64'(timer_o), 64'd8);
        chk("t3_err_trig", 64'(trigger_o), 64'd0);
        tick();
        chk("t3_err_frozen", 64'(timer_o), 64'd8);
        run_en = 1'b0;
        tick();
        chk("t3_off_timer", 64'(timer_o), 64'd0);
        chk("t3_miss_sticky", 64'(miss_err_o), 64'd1);
        tick();
        chk("t3_miss_sticky2", 64'(miss_err_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tiq_head_valid = 1'b0;
        chk("t3_rst_miss", 64'(miss_err_o), 64'd0);

        // Wrap: run to 0xFFFE, then head 0x0001
        run_en = 1'b1;
        tick();
        repeat (16'hFFFE) tick();
        chk("t4_timer_fffe", 64'(timer_o), 64'hFFFE);
        tiq_head_time  = 16'h0001;
        tiq_head_valid = 1'b1;
        evq_i_valid    = 8'h0F;
        evq_i_data     = 64'hFEED_0000_0000_0001;
        tick();
        chk("t4_timer_ffff", 64'(timer_o), 64'hFFFF);
        chk("t4_no_miss_a", 64'(miss_err_o), 64'd0);
        tick();
        chk("t4_timer_wrap", 64'(timer_o), 64'd0);
        chk("t4_no_miss_b", 64'(miss_err_o), 64'd0);
        chk("t4_trig_0", 64'(trigger_o), 64'd0);
        tick();
        chk("t4_trig_1", 64'(trigger_o), 64'd1);
        push_exp(8'h0F, 64'hFEED_0000_0000_0001);
        tick();
        chk("t4_timer2", 64'(timer_o), 64'd2);
        chk("t4_evt", 64'(evt_o_valid), 64'h0F);
        chk("t4_no_miss_c", 64'(miss_err_o), 64'd0);
        tiq_head_valid = 1'b0;
        run_en = 1'b0;
        tick();

        // Back-to-back heads 0x10 and 0x12
        tiq_head_time  = 16'h0010;
        tiq_head_valid = 1'b1;
        evq_i_valid    = 8'h11;
        evq_i_data     = 64'hD1D1_D1D1_D1D1_D1D1;
        run_en         = 1'b1;
        tick();
        repeat (16) tick();
        chk("t5_trig_10", 64'(trigger_o), 64'd1);
        push_exp(8'h11, 64'hD1D1_D1D1_D1D1_D1D1);
        tick();
        chk("t5_evt_11", 64'(evt_o_valid), 64'h11);
        tiq_head_time = 16'h0012;
        evq_i_valid   = 8'h22;
        evq_i_data    = 64'hD2D2_D2D2_D2D2_D2D2;
        tick();
        chk("t5_trig_12", 64'(trigger_o), 64'd1);
        chk("t5_evt_12", 64'(evt_o_valid), 64'h11);
        push_exp(8'h22, 64'hD2D2_D2D2_D2D2_D2D2);
        tick();
        tiq_head_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_timer", 64'(timer_o), 64'(16'h0013 + i));
            chk("t5_evt_hold", 64'(evt_o_valid), 64'h22);
            chk("t5_data_new", evt_o_data, 64'hD2D2_D2D2_D2D2_D2D2);
            tick();
        end
        chk("t5_timer17", 64'(timer_o), 64'h17);
        chk("t5_evt_off", 64'(evt_o_valid), 64'd0);
        run_en = 1'b0;
        tick();

        // Reset while stalled
        tiq_head_time  = 16'h0002;
        tiq_head_valid = 1'b1;
        tiq_clk_ena    = 1'b0;
        run_en         = 1'b1;
        tick();
        repeat (2) tick();
        tick();
        chk("t6_stall", 64'(stall_o), 64'd1);
        rst = 1'b1;
        tick();
        chk("t6_timer", 64'(timer_o), 64'd0);
        chk("t6_trig", 64'(trigger_o), 64'd0);
        chk("t6_stall_off", 64'(stall_o), 64'd0);
        chk("t6_evt_valid", 64'(evt_o_valid), 64'd0);
        chk("t6_evt_data", evt_o_data, 64'd0);
        chk("t6_miss", 64'(miss_err_o), 64'd0);
        rst            = 1'b0;
        run_en         = 1'b0;
        tiq_clk_ena    = 1'b1;
        tiq_head_valid = 1'b0;
        tick();
        tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
